// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

    typedef enum logic [1:0] {RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3} rnd_mode_t;

    typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;

    function automatic fp_class_t classify(input logic exp_ones, input logic exp_zero,
                                           input logic frac_zero, input logic frac_msb);
        fp_class_t c;
        if (exp_zero)
            c = frac_zero ? ZERO : SUB;
        else if (exp_ones)
            c = frac_zero ? INF : (frac_msb ? QNAN : SNAN);
        else
            c = NORM;
        return c;
    endfunction

    // Canonical quiet NaN: positive sign, all-ones exponent, fraction MSB only.
    function automatic logic [63:0] qnan(input int exp_w, input int man_w);
        logic [63:0] q;
        q = ((64'd1 << exp_w) - 64'd1) << man_w;
        q = q | (64'd1 << (man_w - 1));
        return q;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp_lzc #(
    parameter int W  = 11,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count
);

    // The highest set bit is visited last, so it determines the count.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (din[i])
                count = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Four-stage pipelined IEEE754 multiplier (unpack, multiply, normalise, round/pack)
// with valid/ready backpressure, dynamic rounding, subnormal results and IEEE flags.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   dataa,
    input  logic [EXP_W+MAN_W:0]   datab,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact,
    output logic                   nan
);

    localparam int FP_W = 1 + EXP_W + MAN_W;
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW;
    localparam int XW   = 2 * MAN_W + 1;
    localparam int LZW  = $clog2(MW + 1);
    localparam int SHW  = $clog2(MAN_W + 4);
    localparam logic [63:0]     QNAN64 = qnan(EXP_W, MAN_W);
    localparam logic [FP_W-1:0] QNAN_W = QNAN64[FP_W-1:0];

    typedef struct packed {
        logic            sa, sb;
        logic [EW-1:0]   ea, eb;
        logic [MW-1:0]   ma, mb;
        fp_class_t       ca, cb;
        rnd_mode_t       rnd;
    } s1_t;

    typedef struct packed {
        logic            sign;
        logic [EW-1:0]   exp;
        logic [PW-1:0]   prod;
        logic            sp_nan, sp_inf, sp_zero;
        rnd_mode_t       rnd;
    } s2_t;

    typedef struct packed {
        logic            sign;
        logic [EW-1:0]   exp;
        logic [MW-1:0]   mant;
        logic            g, r, s;
        logic            sp_nan, sp_inf, sp_zero;
        rnd_mode_t       rnd;
    } s3_t;

    typedef struct packed {
        logic [FP_W-1:0] result;
        logic            overflow, underflow, inexact, nan;
    } s4_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    s4_t s4_d, s4_q;
    logic v1, v2, v3, v4;
    logic advance;

    assign advance   = !v4 || out_ready;
    assign in_ready  = advance;
    assign out_valid = v4;
    assign result    = s4_q.result;
    assign overflow  = s4_q.overflow;
    assign underflow = s4_q.underflow;
    assign inexact   = s4_q.inexact;
    assign nan       = s4_q.nan;

    // ---------------- S1: unpack / classify ----------------
    logic [LZW-1:0] lza, lzb;

    fp_lzc #(.W(MW), .CW(LZW)) u_lzc_a (.din({1'b0, dataa[MAN_W-1:0]}), .count(lza));
    fp_lzc #(.W(MW), .CW(LZW)) u_lzc_b (.din({1'b0, datab[MAN_W-1:0]}), .count(lzb));

    // Subnormals are renormalised so every finite operand carries a set hidden bit.
    function automatic void unpack(input logic [FP_W-1:0] w, input logic [LZW-1:0] lz,
                                   output logic s, output logic [EW-1:0] e,
                                   output logic [MW-1:0] m, output fp_class_t c);
        s = w[FP_W-1];
        c = classify(&w[FP_W-2:MAN_W], ~|w[FP_W-2:MAN_W], ~|w[MAN_W-1:0], w[MAN_W-1]);
        if (c == SUB) begin
            e = EW'(1 - BIAS) - EW'(lz);
            m = {1'b0, w[MAN_W-1:0]} << lz;
        end else begin
            e = EW'(w[FP_W-2:MAN_W]) - EW'(BIAS);
            m = {1'b1, w[MAN_W-1:0]};
        end
    endfunction

    always_comb begin
        s1_d = '0;
        unpack(dataa, lza, s1_d.sa, s1_d.ea, s1_d.ma, s1_d.ca);
        unpack(datab, lzb, s1_d.sb, s1_d.eb, s1_d.mb, s1_d.cb);
        s1_d.rnd = rnd_mode_t'(rnd_mode);
    end

    // ---------------- S2: multiply ----------------
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    always_comb begin
        a_nan  = (s1_q.ca == QNAN) || (s1_q.ca == SNAN);
        b_nan  = (s1_q.cb == QNAN) || (s1_q.cb == SNAN);
        a_inf  = (s1_q.ca == INF);
        b_inf  = (s1_q.cb == INF);
        a_zero = (s1_q.ca == ZERO);
        b_zero = (s1_q.cb == ZERO);
        s2_d         = '0;
        s2_d.sign    = s1_q.sa ^ s1_q.sb;
        s2_d.exp     = s1_q.ea + s1_q.eb;
        s2_d.prod    = PW'(s1_q.ma) * PW'(s1_q.mb);
        s2_d.sp_nan  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
        s2_d.sp_inf  = a_inf || b_inf;
        s2_d.sp_zero = a_zero || b_zero;
        s2_d.rnd     = s1_q.rnd;
    end

    // ---------------- S3: normalise / denormalise ----------------
    logic [XW-1:0]       x3, mask3;
    logic                st3;
    logic [EW-1:0]       e3;
    logic signed [EW:0]  d3;
    logic [SHW-1:0]      sh3;

    always_comb begin
        if (s2_q.prod[PW-1]) begin
            x3  = s2_q.prod[PW-1:1];
            st3 = s2_q.prod[0];
            e3  = s2_q.exp + EW'(1);
        end else begin
            x3  = s2_q.prod[XW-1:0];
            st3 = 1'b0;
            e3  = s2_q.exp;
        end
        // Distance below the minimum normal exponent; beyond MAN_W+3 everything is sticky anyway.
        d3    = (EW+1)'(1 - BIAS) - $signed({e3[EW-1], e3});
        sh3   = '0;
        mask3 = '0;
        if (!d3[EW] && (d3 != '0)) begin
            sh3   = (d3 > (EW+1)'(MAN_W + 3)) ? SHW'(MAN_W + 3) : SHW'(d3);
            mask3 = ~({XW{1'b1}} << sh3);
            st3   = st3 | (|(x3 & mask3));
            x3    = x3 >> sh3;
            e3    = EW'(1 - BIAS);
        end
        s3_d         = '0;
        s3_d.sign    = s2_q.sign;
        s3_d.exp     = e3;
        s3_d.mant    = x3[XW-1:MAN_W];
        s3_d.g       = x3[MAN_W-1];
        s3_d.r       = x3[MAN_W-2];
        s3_d.s       = st3 | (|x3[MAN_W-3:0]);
        s3_d.sp_nan  = s2_q.sp_nan;
        s3_d.sp_inf  = s2_q.sp_inf;
        s3_d.sp_zero = s2_q.sp_zero;
        s3_d.rnd     = s2_q.rnd;
    end

    // ---------------- S4: round / special cases / pack ----------------
    logic            inc4, inx4, ovf4, to_inf4;
    logic [MW:0]     mr4;
    logic [MW-1:0]   m4;
    logic [EW-1:0]   e4;
    logic [EXP_W-1:0] be4;

    always_comb begin
        inx4 = s3_q.g | s3_q.r | s3_q.s;
        inc4 = 1'b0;
        case (s3_q.rnd)
            RNE: inc4 = s3_q.g & (s3_q.r | s3_q.s | s3_q.mant[0]);
            RTZ: inc4 = 1'b0;
            RUP: inc4 = !s3_q.sign && inx4;
            RDN: inc4 = s3_q.sign && inx4;
            default: inc4 = 1'b0;
        endcase
        mr4 = {1'b0, s3_q.mant} + {{MW{1'b0}}, inc4};
        if (mr4[MW]) begin
            m4 = mr4[MW:1];
            e4 = s3_q.exp + EW'(1);
        end else begin
            m4 = mr4[MW-1:0];
            e4 = s3_q.exp;
        end
        ovf4    = $signed(e4) > $signed(EW'(BIAS));
        to_inf4 = (s3_q.rnd == RNE) || (s3_q.rnd == RUP && !s3_q.sign) ||
                  (s3_q.rnd == RDN && s3_q.sign);
        be4     = m4[MW-1] ? EXP_W'(e4 + EW'(BIAS)) : '0;

        s4_d = '0;
        if (s3_q.sp_nan) begin
            s4_d.result = QNAN_W;
            s4_d.nan    = 1'b1;
        end else if (s3_q.sp_inf) begin
            s4_d.result = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s3_q.sp_zero) begin
            s4_d.result = {s3_q.sign, {(FP_W-1){1'b0}}};
        end else if (ovf4) begin
            s4_d.overflow = 1'b1;
            s4_d.inexact  = 1'b1;
            s4_d.result   = to_inf4 ? {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                    : {s3_q.sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else begin
            s4_d.result    = {s3_q.sign, be4, m4[MAN_W-1:0]};
            s4_d.inexact   = inx4;
            s4_d.underflow = !m4[MW-1] && inx4;
        end
    end

    // Every stage freezes together when the output is blocked; data only loads behind a valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            v4   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
            s4_q <= '0;
        end else if (advance) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
            if (in_valid) s1_q <= s1_d;
            if (v1)       s2_q <= s2_d;
            if (v2)       s3_q <= s3_d;
            if (v3)       s4_q <= s4_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed binary16 bench for fp_mult_pipe: corner-case vectors, stall/backpressure, reset flush.
`timescale 1ns/1ps
module tb_fp_mult_pipe;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dataa = '0;
    logic [15:0] datab = '0;
    logic [1:0]  rnd_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        overflow, underflow, inexact, nan;
    logic [3:0]  flags;

    int vectors = 0;
    int miscompares = 0;

    assign flags = {overflow, underflow, inexact, nan};

    always #5 clock = ~clock;

    fp_mult_pipe dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .overflow(overflow),
        .underflow(underflow), .inexact(inexact), .nan(nan)
    );

    // Single operation on an idle pipeline; lat counts sampling cycles from presentation to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] m,
                          output logic [15:0] res, output logic [3:0] fl, output int lat);
        lat = -1;
        res = 'x;
        fl  = 'x;
        @(negedge clock);
        dataa = a; datab = b; rnd_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (out_valid) begin
                lat = c;
                res = result;
                fl  = flags;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++;
        if (result !== 16'h0000) begin miscompares++; $display("FAIL reset_result: got %h expected 0000", result); end
        vectors++;
        if (flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", flags); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Table-driven vectors: {a, b, mode, expected result, expected {ovf,unf,inx,nan}}.
    task automatic run_table(input string tag, input logic [15:0] ta[], input logic [15:0] tb_[],
                             input logic [1:0] tm[], input logic [15:0] tr[], input logic [3:0] tf[]);
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
        for (int i = 0; i < ta.size(); i++) begin
            run_op(ta[i], tb_[i], tm[i], res, fl, lat);
            vectors++;
            if (res !== tr[i]) begin
                miscompares++;
                $display("FAIL %s[%0d] result %h*%h mode %0d: got %h expected %h", tag, i, ta[i], tb_[i], tm[i], res, tr[i]);
            end
            vectors++;
            if (fl !== tf[i]) begin
                miscompares++;
                $display("FAIL %s[%0d] flags %h*%h mode %0d: got %b expected %b", tag, i, ta[i], tb_[i], tm[i], fl, tf[i]);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
        run_op(16'h3E00, 16'h4000, 2'd0, res, fl, lat);
        vectors++;
        if (res !== 16'h4200) begin miscompares++; $display("FAIL basic_result: got %h expected 4200", res); end
        vectors++;
        if (fl !== 4'b0000) begin miscompares++; $display("FAIL basic_flags: got %b expected 0000", fl); end
        vectors++;
        if (lat != 4) begin miscompares++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    endtask

    task automatic test_overflow();
        run_table("overflow",
            '{16'h7BFF, 16'h7BFF, 16'hFBFF, 16'hFBFF},
            '{16'h4000, 16'h4000, 16'h4000, 16'h4000},
            '{2'd0,     2'd1,     2'd3,     2'd2},
            '{16'h7C00, 16'h7BFF, 16'hFC00, 16'hFBFF},
            '{4'b1010,  4'b1010,  4'b1010,  4'b1010});
    endtask

    task automatic test_underflow();
        run_table("underflow",
            '{16'h0001, 16'h0001, 16'h0200},
            '{16'h3800, 16'h3800, 16'h4000},
            '{2'd0,     2'd2,     2'd0},
            '{16'h0000, 16'h0001, 16'h0400},
            '{4'b0110,  4'b0110,  4'b0000});
    endtask

    task automatic test_special();
        run_table("special",
            '{16'h7C00, 16'h7D00, 16'hFC00},
            '{16'h8000, 16'h3C00, 16'h4000},
            '{2'd0,     2'd0,     2'd0},
            '{16'h7E00, 16'h7E00, 16'hFC00},
            '{4'b0001,  4'b0001,  4'b0000});
    endtask

    // (1+2^-10)^2 = 1 + 2^-9 + 2^-20: guard and round clear, sticky set.
    task automatic test_rounding();
        run_table("rounding",
            '{16'h3C01, 16'h3C01, 16'h3C01, 16'hBC01},
            '{16'h3C01, 16'h3C01, 16'h3C01, 16'h3C01},
            '{2'd0,     2'd2,     2'd1,     2'd3},
            '{16'h3C02, 16'h3C03, 16'h3C02, 16'hBC03},
            '{4'b0010,  4'b0010,  4'b0010,  4'b0010});
    endtask

    task automatic test_stall();
        logic [15:0] pa[6], pb[6], er[6];
        logic [15:0] held;
        int sent, got, extra;
        logic stable, blocked;
        pa = '{16'h3C00, 16'h4000, 16'h3E00, 16'hC000, 16'h3800, 16'h4200};
        pb = '{16'h3C00, 16'h4000, 16'h4000, 16'h3C00, 16'h3800, 16'h4200};
        er = '{16'h3C00, 16'h4400, 16'h4200, 16'hC000, 16'h3400, 16'h4880};
        sent = 0; got = 0; extra = 0; stable = 1'b1; blocked = 1'b1; held = 'x;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            out_ready = 1'b0;
            rnd_mode  = 2'd0;
            in_valid  = (sent < 6);
            if (sent < 6) begin dataa = pa[sent]; datab = pb[sent]; end
            #1;
            if (c == 4) held = result;
            if (c >= 4) begin
                if (!out_valid || result !== held) stable = 1'b0;
                if (in_ready) blocked = 1'b0;
            end
            if (in_valid && in_ready) sent++;
        end
        vectors++;
        if (sent != 4) begin miscompares++; $display("FAIL stall_accepted: got %0d expected 4", sent); end
        vectors++;
        if (held !== er[0]) begin miscompares++; $display("FAIL stall_head: got %h expected %h", held, er[0]); end
        vectors++;
        if (!stable || !blocked) begin miscompares++; $display("FAIL stall_hold: stable %b blocked %b expected 1 1", stable, blocked); end
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clock);
            out_ready = 1'b1;
            in_valid  = (sent < 6);
            if (sent < 6) begin dataa = pa[sent]; datab = pb[sent]; end
            #1;
            if (out_valid) begin
                vectors++;
                if (result !== er[got]) begin
                    miscompares++;
                    $display("FAIL stall_drain[%0d]: got %h expected %h", got, result, er[got]);
                end
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 6) begin miscompares++; $display("FAIL stall_count: got %0d expected 6", got); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (out_valid) extra++;
        end
        vectors++;
        if (extra != 0) begin miscompares++; $display("FAIL stall_duplicate: got %0d extra expected 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            out_ready = 1'b1; in_valid = 1'b1; rnd_mode = 2'd0;
            dataa = 16'h3C00 + 16'(c); datab = 16'h4000;
        end
        @(negedge clock);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midflight_pre: got %b expected 1", out_valid); end
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midflight_valid: got %b expected 0", out_valid); end
        vectors++;
        if (result !== 16'h0000 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL midflight_clear: got %h/%b expected 0000/0000", result, flags);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (out_valid) stale++;
        end
        vectors++;
        if (stale != 0) begin miscompares++; $display("FAIL midflight_stale: got %0d outputs expected 0", stale); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_special();
        test_rounding();
        test_stall();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
